// File: rtl/board_pkg.sv
// Shared types, defaults and helpers for the 2048 move engine.
// Directions, FSM states, cell index mapping and LFSR step.
package board_pkg;

    localparam int N_DEF       = 4;
    localparam int TILE_W_DEF  = 20;
    localparam int SCORE_W_DEF = 21;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLIDE = 2'd1,
        ST_SPAWN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Element j of line k, counted from the edge tiles move toward.
    function automatic int cell_idx(
        input int         n,
        input logic [1:0] d,
        input int         k,
        input int         j
    );
        int idx;
        idx = 0;
        unique case (d)
            DIR_LEFT:  idx = k * n + j;
            DIR_RIGHT: idx = k * n + (n - 1 - j);
            DIR_UP:    idx = j * n + k;
            DIR_DOWN:  idx = (n - 1 - j) * n + k;
        endcase
        return idx;
    endfunction

    // Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

endpackage

// File: rtl/board_move_engine_if.sv
// Request/result bundle between the game controller and the move engine.
// master = controller side, slave = engine side.
interface board_move_engine_if
    import board_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int TILE_W  = TILE_W_DEF,
    parameter int SCORE_W = SCORE_W_DEF
);
    logic                    start;
    logic [1:0]              dir;
    logic [N*N*TILE_W-1:0]   board_in;
    logic [N*N*TILE_W-1:0]   board_out;
    logic [SCORE_W-1:0]      score_add;
    logic                    moved;
    logic                    game_over;
    logic                    win;
    logic                    busy;
    logic                    done;

    modport master (
        output start, dir, board_in,
        input  board_out, score_add, moved,
        input  game_over, win, busy, done
    );

    modport slave (
        input  start, dir, board_in,
        output board_out, score_add, moved,
        output game_over, win, busy, done
    );
endinterface

// File: rtl/line_merge.sv
// Combinational 2048 line slide: compress, merge pairs from the leading
// edge (element 0), compress again; reports merged score and change flag.
module line_merge #(
    parameter int N       = 4,
    parameter int TILE_W  = 20,
    parameter int SCORE_W = 21
) (
    input  logic [N*TILE_W-1:0] i_line,
    output logic [N*TILE_W-1:0] o_line,
    output logic [SCORE_W-1:0]  o_score,
    output logic                o_moved
);
    typedef logic [N-1:0][TILE_W-1:0] line_t;

    localparam int AW = ((SCORE_W > TILE_W) ? SCORE_W : TILE_W) + 1;
    localparam logic [TILE_W-1:0]  W_MAX = {1'b1, {(TILE_W-1){1'b0}}};
    localparam logic [SCORE_W-1:0] S_MAX = '1;

    function automatic line_t compress(input line_t l);
        line_t t;
        t = l;
        for (int p = 0; p < N - 1; p++) begin
            for (int i = 0; i < N - 1; i++) begin
                if (t[i] == '0) begin
                    t[i]   = t[i+1];
                    t[i+1] = '0;
                end
            end
        end
        return t;
    endfunction

    line_t             w_c;
    line_t             w_m;
    line_t             w_out;
    logic [SCORE_W-1:0] w_acc;
    logic [AW-1:0]      w_sum;

    // Zeroing the partner keeps a merged tile from merging again.
    always_comb begin
        w_c   = compress(i_line);
        w_m   = w_c;
        w_acc = '0;
        w_sum = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (w_m[i] != '0 && w_m[i] < W_MAX && w_m[i] == w_m[i+1]) begin
                w_m[i]   = w_m[i] << 1;
                w_m[i+1] = '0;
                w_sum    = AW'(w_acc) + AW'(w_m[i]);
                w_acc    = (w_sum > AW'(S_MAX)) ? S_MAX : SCORE_W'(w_sum);
            end
        end
        w_out = compress(w_m);
    end

    assign o_line  = w_out;
    assign o_score = w_acc;
    assign o_moved = (w_out != line_t'(i_line));

endmodule

// File: rtl/board_move_engine.sv
// NxN 2048 move engine: one line per cycle, then random spawn and result.
// Optional win flag built only when BOARD_MOVE_WIN_EN is defined.
module board_move_engine
    import board_pkg::*;
#(
    parameter int          N         = N_DEF,
    parameter int          TILE_W    = TILE_W_DEF,
    parameter int          SCORE_W   = SCORE_W_DEF,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
`ifdef BOARD_MOVE_WIN_EN
    ,
    parameter int          WIN_VALUE = 2048
`endif
) (
    input logic               clk,
    input logic               rst,
    board_move_engine_if.slave bus
);
    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int KW = $clog2(N);

    state_e                      r_state;
    logic [1:0]                  r_dir;
    logic [KW-1:0]               r_k;
    logic [15:0]                 r_lfsr;
    logic [NN-1:0][TILE_W-1:0]   r_cells;
    logic [SCORE_W-1:0]          r_score;
    logic                        r_moved;
    logic                        r_busy;
    logic                        r_done;
    logic [NN-1:0][TILE_W-1:0]   r_obrd;
    logic [SCORE_W-1:0]          r_oscore;
    logic                        r_omoved;
    logic                        r_oover;
    logic                        r_owin;

    logic [N-1:0][IW-1:0]        w_gidx;
    logic [N-1:0][TILE_W-1:0]    w_lin;
    logic [N-1:0][TILE_W-1:0]    w_lout;
    logic [SCORE_W-1:0]          w_lscore;
    logic                        w_lmoved;
    logic [SCORE_W:0]            w_sum;
    logic [IW-1:0]               w_p;
    logic [IW-1:0]               w_spos;
    logic                        w_sfound;
    logic                        w_over;
    logic                        w_win;

    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_gidx[j] = IW'(cell_idx(N, r_dir, int'(r_k), j));
            w_lin[j]  = r_cells[w_gidx[j]];
        end
    end

    line_merge #(
        .N       (N),
        .TILE_W  (TILE_W),
        .SCORE_W (SCORE_W)
    ) u_merge (
        .i_line  (w_lin),
        .o_line  (w_lout),
        .o_score (w_lscore),
        .o_moved (w_lmoved)
    );

    assign w_sum = {1'b0, r_score} + {1'b0, w_lscore};

    // First empty cell at or after the random start index, wrapping.
    always_comb begin
        w_sfound = 1'b0;
        w_spos   = '0;
        w_p      = '0;
        for (int o = 0; o < NN; o++) begin
            w_p = r_lfsr[IW-1:0] + IW'(o);
            if (!w_sfound && r_cells[w_p] == '0) begin
                w_sfound = 1'b1;
                w_spos   = w_p;
            end
        end
    end

    always_comb begin
        w_over = 1'b1;
        for (int i = 0; i < NN; i++)
            if (r_cells[i] == '0) w_over = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N - 1; c++)
                if (r_cells[r*N+c] == r_cells[r*N+c+1]) w_over = 1'b0;
        for (int r = 0; r < N - 1; r++)
            for (int c = 0; c < N; c++)
                if (r_cells[r*N+c] == r_cells[(r+1)*N+c]) w_over = 1'b0;
    end

`ifdef BOARD_MOVE_WIN_EN
    always_comb begin
        w_win = 1'b0;
        for (int i = 0; i < NN; i++)
            if (r_cells[i] >= TILE_W'(WIN_VALUE)) w_win = 1'b1;
    end
`else
    assign w_win = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_dir    <= DIR_LEFT;
            r_k      <= '0;
            r_lfsr   <= LFSR_SEED;
            r_cells  <= '0;
            r_score  <= '0;
            r_moved  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_obrd   <= '0;
            r_oscore <= '0;
            r_omoved <= 1'b0;
            r_oover  <= 1'b0;
            r_owin   <= 1'b0;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // The done cycle still counts as busy.
                    if (bus.start && !r_done) begin
                        r_cells <= bus.board_in;
                        r_dir   <= bus.dir;
                        r_score <= '0;
                        r_moved <= 1'b0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SLIDE;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_SLIDE: begin
                    for (int j = 0; j < N; j++)
                        r_cells[w_gidx[j]] <= w_lout[j];
                    r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
                    r_moved <= r_moved | w_lmoved;
                    if (r_k == KW'(N - 1)) r_state <= ST_SPAWN;
                    else                   r_k     <= r_k + 1'b1;
                end
                ST_SPAWN: begin
                    if (r_moved && w_sfound)
                        r_cells[w_spos] <= (r_lfsr[15:13] == 3'b000)
                                         ? TILE_W'(4) : TILE_W'(2);
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_obrd   <= r_cells;
                    r_oscore <= r_score;
                    r_omoved <= r_moved;
                    r_oover  <= w_over;
                    r_owin   <= w_win;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.board_out = r_obrd;
    assign bus.score_add = r_oscore;
    assign bus.moved     = r_omoved;
    assign bus.game_over = r_oover;
    assign bus.win       = r_owin;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
